state_cmd_receiver: RTL



---
 rtl/state_cmd_pkg.sv | 31 +++
 rtl/cmd_ack_tx.sv | 105 ++++++++++
 rtl/state_cmd_receiver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/state_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : state_cmd_pkg
// Brief    : Shared widths, constants and state types for the command receiver.
// Revision : 1.0 - initial release
// ============================================================================
package state_cmd_pkg;

   localparam int          CMD_W            = 2;
   localparam logic [15:0] CMD_PKT_LEN      = 16'd1;
   localparam logic [5:0]  ACK_MARK_DEFAULT = 6'b101000;

   typedef enum logic [0:0] {
      RX_IDLE  = 1'b0,
      RX_BURST = 1'b1
   } rx_state_t;

   typedef enum logic [1:0] {
      A_IDLE = 2'd0,
      A_REQ  = 2'd1,
      A_SEND = 2'd2,
      A_WAIT = 2'd3
   } ack_state_t;

   function automatic logic [7:0] ack_byte(input logic [5:0] mark,
                                           input logic [CMD_W-1:0] cmd);
      return {mark, cmd};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_ack_tx.sv
`default_nettype none
// ============================================================================
// Module   : cmd_ack_tx
// Brief    : Single-slot ACK sender driving the UDP TX request/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_ack_tx
   import state_cmd_pkg::*;
#(
   parameter logic [5:0] ACK_MARK = ACK_MARK_DEFAULT
)(
   input  logic             clk_50,
   input  logic             sys_rst_n,
   input  logic             ack_req,
   input  logic [CMD_W-1:0] ack_cmd,
   input  logic             udp_tx_ready,
   input  logic             app_tx_ack,
   output logic             app_tx_data_request,
   output logic             app_tx_data_valid,
   output logic [7:0]       app_tx_data,
   output logic             ack_overrun
);

   ack_state_t       r_state;
   ack_state_t       w_state_nxt;
   logic [CMD_W-1:0] r_cmd;
   logic [CMD_W-1:0] w_cmd_nxt;
   logic             r_req;
   logic             w_req_nxt;
   logic             r_dv;
   logic             w_dv_nxt;
   logic [7:0]       r_data;
   logic [7:0]       w_data_nxt;
   logic             r_ovr;
   logic             w_ovr_nxt;

   always_ff @(posedge clk_50 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= A_IDLE;
         r_cmd   <= '0;
         r_req   <= 1'b0;
         r_dv    <= 1'b0;
         r_data  <= 8'h00;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cmd   <= w_cmd_nxt;
         r_req   <= w_req_nxt;
         r_dv    <= w_dv_nxt;
         r_data  <= w_data_nxt;
         r_ovr   <= w_ovr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_nxt   = r_cmd;
      w_req_nxt   = r_req;
      w_dv_nxt    = r_dv;
      w_data_nxt  = r_data;
      w_ovr_nxt   = 1'b0;
      case (r_state)
         A_IDLE: begin
            if (ack_req) begin
               w_cmd_nxt   = ack_cmd;
               w_state_nxt = A_REQ;
            end
         end
         A_REQ: begin
            if (udp_tx_ready) begin
               w_req_nxt   = 1'b1;
               w_state_nxt = A_SEND;
            end
         end
         A_SEND: begin
            if (app_tx_ack) begin
               w_req_nxt   = 1'b0;
               w_dv_nxt    = 1'b1;
               w_data_nxt  = ack_byte(ACK_MARK, r_cmd);
               w_state_nxt = A_WAIT;
            end
         end
         A_WAIT: begin
            w_dv_nxt = 1'b0;
            if (udp_tx_ready) begin
               w_state_nxt = A_IDLE;
            end
         end
         default: begin
            w_state_nxt = A_IDLE;
         end
      endcase
      // Only one ACK can be in flight; a request arriving while busy is lost.
      if (ack_req && (r_state != A_IDLE)) begin
         w_ovr_nxt = 1'b1;
      end
   end

   assign app_tx_data_request = r_req;
   assign app_tx_data_valid   = r_dv;
   assign app_tx_data         = r_data;
   assign ack_overrun         = r_ovr;

endmodule
`default_nettype wire

// File: rtl/state_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : state_cmd_receiver
// Brief    : Parses 1-byte UDP command datagrams and optionally returns an ACK.
// Revision : 1.0 - initial release
// ============================================================================
module state_cmd_receiver
   import state_cmd_pkg::*;
#(
   parameter logic [15:0] LISTEN_PORT = 16'd8080,
   parameter bit          ACK_ENABLE  = 1'b1,
   parameter logic [5:0]  ACK_MARK    = ACK_MARK_DEFAULT
)(
   input  logic             clk_50,
   input  logic             sys_rst_n,
   input  logic             app_rx_data_valid,
   input  logic [7:0]       app_rx_data,
   input  logic [15:0]      app_rx_data_length,
   input  logic [15:0]      app_rx_port_num,
   output logic [CMD_W-1:0] cmd_out,
   output logic             cmd_valid,
   output logic             cmd_error,
   output logic [15:0]      rx_count,
   output logic [7:0]       err_count,
   output logic             ack_overrun,
   input  logic             udp_tx_ready,
   input  logic             app_tx_ack,
   output logic             app_tx_data_request,
   output logic             app_tx_data_valid,
   output logic [7:0]       app_tx_data,
   output logic [15:0]      udp_data_length
);

   rx_state_t   r_rx_state;
   rx_state_t   w_rx_state_nxt;
   logic [7:0]  r_byte;
   logic [15:0] r_len;
   logic [15:0] r_port;
   logic [15:0] r_byte_cnt;
   logic        w_start;
   logic        w_eval;
   logic        w_accept;

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_start        = 1'b0;
      w_eval         = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            if (app_rx_data_valid) begin
               w_start        = 1'b1;
               w_rx_state_nxt = RX_BURST;
            end
         end
         RX_BURST: begin
            if (!app_rx_data_valid) begin
               w_eval         = 1'b1;
               w_rx_state_nxt = RX_IDLE;
            end
         end
         default: begin
            w_rx_state_nxt = RX_IDLE;
         end
      endcase
   end

   assign w_accept = w_eval
                   && (r_byte_cnt == CMD_PKT_LEN)
                   && (r_len == CMD_PKT_LEN)
                   && (r_port == LISTEN_PORT)
                   && (r_byte[7:CMD_W] == '0);

   // Only the first byte of a run is kept; later bytes merely count.
   always_ff @(posedge clk_50 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rx_state <= RX_IDLE;
         r_byte     <= 8'h00;
         r_len      <= 16'd0;
         r_port     <= 16'd0;
         r_byte_cnt <= 16'd0;
      end else begin
         r_rx_state <= w_rx_state_nxt;
         if (w_start) begin
            r_byte     <= app_rx_data;
            r_len      <= app_rx_data_length;
            r_port     <= app_rx_port_num;
            r_byte_cnt <= 16'd1;
         end else if ((r_rx_state == RX_BURST) && app_rx_data_valid
                      && (r_byte_cnt != 16'hFFFF)) begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_50 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cmd_out   <= '0;
         cmd_valid <= 1'b0;
         cmd_error <= 1'b0;
         rx_count  <= 16'd0;
         err_count <= 8'd0;
      end else begin
         cmd_valid <= w_accept;
         cmd_error <= w_eval && !w_accept;
         if (w_accept) begin
            cmd_out <= r_byte[CMD_W-1:0];
            if (rx_count != 16'hFFFF) begin
               rx_count <= rx_count + 16'd1;
            end
         end
         if (w_eval && !w_accept && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

   generate
      if (ACK_ENABLE) begin : g_ack
         cmd_ack_tx #(
            .ACK_MARK (ACK_MARK)
         ) u_ack (
            .clk_50              (clk_50),
            .sys_rst_n           (sys_rst_n),
            .ack_req             (w_accept),
            .ack_cmd             (r_byte[CMD_W-1:0]),
            .udp_tx_ready        (udp_tx_ready),
            .app_tx_ack          (app_tx_ack),
            .app_tx_data_request (app_tx_data_request),
            .app_tx_data_valid   (app_tx_data_valid),
            .app_tx_data         (app_tx_data),
            .ack_overrun         (ack_overrun)
         );
      end else begin : g_no_ack
         assign app_tx_data_request = 1'b0;
         assign app_tx_data_valid   = 1'b0;
         assign app_tx_data         = 8'h00;
         assign ack_overrun         = 1'b0;
      end
   endgenerate

   assign udp_data_length = CMD_PKT_LEN;

endmodule
`default_nettype wire
